mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Data-memory access controller for the memory stage. It sits between the EX/MEM pipeline latch and the MEM/WB latch. It issues load/store requests to the data cache and waits for dhit. It then produces the load data and the memory_en advance strobe that the MEM/WB latch consumes, and holds upstream stages stalled while an access is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max wait cycles for dhit before bus error (1..2^16-1)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
ex_valid  in  1  EX/MEM latch holds a valid instruction
ex_ren  in  1  instruction is a load
ex_wen  in  1  instruction is a store
ex_halt  in  1  instruction is halt
ex_addr  in  ADDR_W  effective address (ALU result)
ex_store  in  DATA_W  store data
flush  in  1  squash current instruction
dhit  in  1  cache completed request this cycle
dmemload  in  DATA_W  cache read data
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  ADDR_W  cache address
dmemstore  out  DATA_W  cache write data
dload  out  DATA_W  load data to MEM/WB latch
memory_en  out  1  MEM/WB latch advance strobe
stall  out  1  freeze upstream latches
kill  out  1  with memory_en: suppress register write (misaligned or flushed)
halt  out  1  sticky halt reached
err  out  1  sticky bus timeout
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- States: IDLE, ACCESS, HALTED, ERROR. Reset (RST high at edge, including mid-access): state=IDLE, wait counter=0, every registered output 0, dmemREN/dmemWEN low from that edge.
- IDLE, ex_valid=0: memory_en=0, stall=0.
- IDLE, ex_valid, no mem op, no halt: memory_en=1 combinationally in the same cycle. kill=flush. stall=0.
- IDLE, ex_valid, ex_halt (halt has priority over ren/wen): memory_en=1 the same cycle, next state HALTED.
- IDLE, mem op, ex_addr[1:0]!=0: no cache request. memory_en=1, kill=1 in the same cycle. Stay IDLE.
- IDLE, mem op aligned, flush=0:
  - Register addr/store/ren/wen.
  - Next state ACCESS.
  - stall=1 this cycle; memory_en=0.
  - If both ren and wen are set, wen wins.
- IDLE, mem op, flush=1: memory_en=1, kill=1, no request.
- ACCESS:
  - dmemREN/dmemWEN/dmemaddr/dmemstore are driven from registers and held stable until dhit.
  - stall=1 except in the dhit cycle.
  - On dhit:
    - dload=dmemload for a load, 0 for a store, registered and held until the next completion.
    - memory_en=1 combinationally.
    - Requests deassert at the next edge; next state IDLE.
  - flush during ACCESS: the bus request is not aborted; the access completes. A pending-kill flag is set; memory_en still pulses at dhit, with kill=1.
  - Wait counter increments each ACCESS cycle without dhit. When it reaches TIMEOUT: next state ERROR, requests drop.
- HALTED: absorbing until reset. halt=1, stall=1, memory_en=0, no requests.
- ERROR: absorbing until reset. err=1, stall=1, memory_en=0.
- stall_cnt increments each cycle stall=1 and saturates at 0xFFFFFFFF.
- memory_en never asserts for more than one cycle per instruction.

Test Plan:
- Reset mid-access: load to 0x100, dhit held low 3 cycles, RST pulse -> dmemREN=0 after the edge, state IDLE, outputs 0, stall_cnt=0.
- Load hit after 2 wait cycles:
  - Stimulus: ex_ren, addr 0x40; dhit in the 3rd ACCESS cycle with dmemload=0xDEADBEEF.
  - Required: stall high 3 cycles, memory_en one pulse coincident with dhit, dload=0xDEADBEEF, stall_cnt=3.
- Store, misaligned:
  - Stimulus: ex_wen, addr 0x42, store 0x12345678.
  - Required: no dmemWEN, memory_en=1 and kill=1 the same cycle, stall=0.
- Flush during ACCESS:
  - Stimulus: store 0x80, flush in the 1st ACCESS cycle, dhit in the 2nd.
  - Required: dmemWEN held until dhit, memory_en=1 with kill=1.
- Timeout with TIMEOUT=4: load, dhit never arrives -> ERROR entered after 4 wait cycles, err=1 sticky, requests low, memory_en never asserted.
- Halt:
  - Stimulus: ex_halt with ex_ren=1.
  - Required: memory_en pulse, no request, halt=1 and stall=1 permanently; later ex_valid ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage data access controller: issues cache load/store requests, waits for dhit,
// and produces load data plus the single-cycle MEM/WB advance strobe.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic              ex_ren,
  input  logic              ex_wen,
  input  logic              ex_halt,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store,
  input  logic              flush,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dload,
  output logic              memory_en,
  output logic              stall,
  output logic              kill,
  output logic              halt,
  output logic              err,
  output logic [31:0]       stall_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req_ren;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_store;
  logic              pend_kill;
  logic              issue;
  logic              mem_op;
  logic              misaligned;

  assign mem_op     = ex_ren | ex_wen;
  assign misaligned = (ex_addr[1:0] != 2'b00);

  // Next-state and same-cycle handshake outputs
  always_comb begin
    next_state = state;
    memory_en  = 1'b0;
    kill       = 1'b0;
    stall      = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (ex_halt) begin
            memory_en  = 1'b1;
            kill       = flush;
            next_state = HALTED;
          end else if (mem_op) begin
            if (misaligned || flush) begin
              memory_en = 1'b1;
              kill      = 1'b1;
            end else begin
              issue      = 1'b1;
              stall      = 1'b1;
              next_state = ACCESS;
            end
          end else begin
            memory_en = 1'b1;
            kill      = flush;
          end
        end
      end
      ACCESS: begin
        if (dhit) begin
          memory_en  = 1'b1;
          kill       = pend_kill | flush;
          next_state = IDLE;
        end else begin
          stall = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            next_state = ERROR;
          end
        end
      end
      HALTED:  stall = 1'b1;
      ERROR:   stall = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  // State, request latch, wait counter, load data and stall statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_ren   <= 1'b0;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_store <= '0;
      pend_kill <= 1'b0;
      dload     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (issue) begin
        req_addr  <= ex_addr;
        req_store <= ex_store;
        req_wen   <= ex_wen;
        req_ren   <= ex_ren & ~ex_wen;
        wait_cnt  <= '0;
        pend_kill <= 1'b0;
      end else if (state == ACCESS) begin
        if (dhit) begin
          dload     <= req_ren ? dmemload : '0;
          pend_kill <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (flush) begin
            pend_kill <= 1'b1;
          end
        end
      end
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  // Requests are only visible while an access is outstanding
  assign dmemREN   = (state == ACCESS) & req_ren;
  assign dmemWEN   = (state == ACCESS) & req_wen;
  assign dmemaddr  = req_addr;
  assign dmemstore = req_store;
  assign halt      = (state == HALTED);
  assign err       = (state == ERROR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4); inputs change on the falling edge.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_ren, ex_wen, ex_halt, flush, dhit;
  logic [31:0] ex_addr, ex_store, dmemload;
  logic        dmemREN, dmemWEN, memory_en, stall, kill, halt, err;
  logic [31:0] dmemaddr, dmemstore, dload, stall_cnt;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_ren(ex_ren), .ex_wen(ex_wen),
    .ex_halt(ex_halt), .ex_addr(ex_addr), .ex_store(ex_store), .flush(flush),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dload(dload), .memory_en(memory_en),
    .stall(stall), .kill(kill), .halt(halt), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    ex_valid = 0; ex_ren = 0; ex_wen = 0; ex_halt = 0; flush = 0; dhit = 0;
    ex_addr = 0; ex_store = 0; dmemload = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1;
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    #1;
    total++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin bad++; $display("FAIL reset_req: ren=%0b wen=%0b want 0 0", dmemREN, dmemWEN); end
    total++; if (memory_en !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_men_stall: men=%0b stall=%0b want 0 0", memory_en, stall); end
    total++; if (halt !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_halt_err: halt=%0b err=%0b want 0 0", halt, err); end
    total++; if (dload !== 32'h0 || stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_regs: dload=%h cnt=%0d want 0 0", dload, stall_cnt); end
  endtask

  task automatic test_passthru();
    @(negedge CLK);
    ex_valid = 1; flush = 0;
    #1;
    total++; if (memory_en !== 1'b1 || kill !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL nop: men=%0b kill=%0b stall=%0b want 1 0 0", memory_en, kill, stall); end
    @(negedge CLK);
    flush = 1;
    #1;
    total++; if (memory_en !== 1'b1 || kill !== 1'b1) begin bad++; $display("FAIL nop_flush: men=%0b kill=%0b want 1 1", memory_en, kill); end
    @(negedge CLK);
    idle_inputs();
    #1;
    total++; if (memory_en !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL no_valid: men=%0b stall=%0b want 0 0", memory_en, stall); end
  endtask

  task automatic test_load_hit();
    int pulses = 0;
    int stalls = 0;
    @(negedge CLK);
    ex_valid = 1; ex_ren = 1; ex_addr = 32'h40;
    #1;
    total++; if (stall !== 1'b1 || memory_en !== 1'b0 || dmemREN !== 1'b0) begin bad++; $display("FAIL ld_issue: stall=%0b men=%0b ren=%0b want 1 0 0", stall, memory_en, dmemREN); end
    stalls += int'(stall); pulses += int'(memory_en);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 2) begin dhit = 1; dmemload = 32'hDEADBEEF; end
      #1;
      total++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h40) begin bad++; $display("FAIL ld_req%0d: ren=%0b wen=%0b addr=%h want 1 0 40", i, dmemREN, dmemWEN, dmemaddr); end
      total++; if (memory_en !== (i == 2) || stall !== (i != 2)) begin bad++; $display("FAIL ld_cyc%0d: men=%0b stall=%0b", i, memory_en, stall); end
      stalls += int'(stall); pulses += int'(memory_en);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    pulses += int'(memory_en);
    total++; if (dload !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_data: got %h want deadbeef", dload); end
    total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL ld_drop: ren=%0b want 0", dmemREN); end
    total++; if (stall_cnt !== 32'd3 || stalls != 3) begin bad++; $display("FAIL ld_stall_cnt: cnt=%0d seen=%0d want 3 3", stall_cnt, stalls); end
    total++; if (pulses != 1) begin bad++; $display("FAIL ld_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_store_misaligned();
    @(negedge CLK);
    ex_valid = 1; ex_wen = 1; ex_addr = 32'h42; ex_store = 32'h12345678;
    #1;
    total++; if (dmemWEN !== 1'b0 || memory_en !== 1'b1 || kill !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL st_mis: wen=%0b men=%0b kill=%0b stall=%0b want 0 1 1 0", dmemWEN, memory_en, kill, stall); end
    @(negedge CLK);
    idle_inputs();
    #1;
    total++; if (dmemWEN !== 1'b0 || stall_cnt !== 32'd3) begin bad++; $display("FAIL st_mis_after: wen=%0b cnt=%0d want 0 3", dmemWEN, stall_cnt); end
  endtask

  task automatic test_flush_access();
    @(negedge CLK);
    ex_valid = 1; ex_wen = 1; ex_addr = 32'h80; ex_store = 32'hCAFEF00D;
    #1;
    total++; if (stall !== 1'b1 || memory_en !== 1'b0) begin bad++; $display("FAIL fl_issue: stall=%0b men=%0b want 1 0", stall, memory_en); end
    @(negedge CLK);
    flush = 1;
    #1;
    total++; if (dmemWEN !== 1'b1 || dmemaddr !== 32'h80 || dmemstore !== 32'hCAFEF00D) begin bad++; $display("FAIL fl_req: wen=%0b addr=%h data=%h", dmemWEN, dmemaddr, dmemstore); end
    total++; if (memory_en !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL fl_wait: men=%0b stall=%0b want 0 1", memory_en, stall); end
    @(negedge CLK);
    flush = 0; dhit = 1;
    #1;
    total++; if (dmemWEN !== 1'b1 || memory_en !== 1'b1 || kill !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL fl_hit: wen=%0b men=%0b kill=%0b stall=%0b want 1 1 1 0", dmemWEN, memory_en, kill, stall); end
    @(negedge CLK);
    idle_inputs();
    #1;
    total++; if (dmemWEN !== 1'b0 || dload !== 32'h0 || stall_cnt !== 32'd5) begin bad++; $display("FAIL fl_after: wen=%0b dload=%h cnt=%0d want 0 0 5", dmemWEN, dload, stall_cnt); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge CLK);
    ex_valid = 1; ex_ren = 1; ex_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      total++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h100) begin bad++; $display("FAIL rm_req%0d: ren=%0b addr=%h want 1 100", i, dmemREN, dmemaddr); end
    end
    RST = 1;
    @(negedge CLK);
    RST = 0;
    idle_inputs();
    #1;
    total++; if (dmemREN !== 1'b0 || stall !== 1'b0 || memory_en !== 1'b0) begin bad++; $display("FAIL rm_outs: ren=%0b stall=%0b men=%0b want 0 0 0", dmemREN, stall, memory_en); end
    total++; if (stall_cnt !== 32'd0 || dload !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL rm_regs: cnt=%0d dload=%h err=%0b want 0 0 0", stall_cnt, dload, err); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    @(negedge CLK);
    ex_valid = 1; ex_ren = 1; ex_addr = 32'h200;
    #1;
    pulses += int'(memory_en);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      pulses += int'(memory_en);
      total++; if (dmemREN !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL to_wait%0d: ren=%0b err=%0b want 1 0", i, dmemREN, err); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ex_valid = (i != 1);
      #1;
      pulses += int'(memory_en);
      total++; if (err !== 1'b1 || dmemREN !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL to_err%0d: err=%0b ren=%0b stall=%0b want 1 0 1", i, err, dmemREN, stall); end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL to_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_halt();
    @(negedge CLK);
    ex_valid = 1; ex_halt = 1; ex_ren = 1; ex_addr = 32'h40;
    #1;
    total++; if (memory_en !== 1'b1 || dmemREN !== 1'b0) begin bad++; $display("FAIL hl_pulse: men=%0b ren=%0b want 1 0", memory_en, dmemREN); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ex_halt = 0; ex_ren = 1; ex_valid = 1;
      #1;
      total++; if (halt !== 1'b1 || stall !== 1'b1 || memory_en !== 1'b0 || dmemREN !== 1'b0) begin bad++; $display("FAIL hl_hold%0d: halt=%0b stall=%0b men=%0b ren=%0b want 1 1 0 0", i, halt, stall, memory_en, dmemREN); end
    end
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_load_hit();
    test_store_misaligned();
    test_flush_access();
    test_reset_mid_access();
    test_timeout();
    apply_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
